mem_access_unit: RTL and testbench

- CPU-side initiator for the word-only data memory; sits between the MEM pipeline stage and the data memory.
- Accepts RV32 load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW) and issues word-aligned 4-byte memory transactions.
- For loads, extracts the byte or halfword lane and sign- or zero-extends it.
- Implements SB/SH as read-modify-write, since the memory writes whole words only.
- Stalls the pipeline via cpu_busywait.

---
 rtl/mem_access_unit_pkg.sv | 58 +++++
 rtl/mem_access_unit_if.sv | 41 ++++
 rtl/mem_lane_align.sv | 67 ++++++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Purpose : shared types and constants for the RV32 load/store memory access
//           unit: FSM state encoding, load funct3 / store size codes, the
//           word-only memory strobe encodings, and small decode helpers.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mem_access_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_FMT,
    S_WR,
    S_DONE
  } state_t;

  // Load funct3 encodings (cpu_read[2:0])
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store size encodings (cpu_write[1:0]); also the internal access size code
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // The memory only ever sees whole-word transactions
  localparam logic [3:0] MEM_RD_WORD = 4'b1010;
  localparam logic [2:0] MEM_WR_WORD = 3'b110;

  // Unused load encodings (011, 11x) fall through to a word access
  function automatic logic [1:0] load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      F3_LW:         return SZ_W;
      default:       return SZ_W;
    endcase
  endfunction

  // Unused store encoding 11 behaves as a word store
  function automatic logic [1:0] store_size(input logic [1:0] sz);
    case (sz)
      SZ_B:    return SZ_B;
      SZ_H:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Purpose : bundles the CPU-side request/response signals and the data-memory
//           bus of the memory access unit.
// Signals : cpu_read[3:0], cpu_write[2:0], cpu_address, cpu_writedata  (CPU req)
//           cpu_readdata, cpu_busywait                                 (CPU rsp)
//           mem_read[3:0], mem_write[2:0], mem_address, mem_writedata  (mem req)
//           mem_readdata, mem_busywait                                 (mem rsp)
// Modports: slave  - the access unit's view (serves the CPU, drives memory)
//           master - the environment's view (CPU stage plus data memory)
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [3:0]            cpu_read;
  logic [2:0]            cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [31:0]           cpu_writedata;
  logic [31:0]           cpu_readdata;
  logic                  cpu_busywait;
  logic [3:0]            mem_read;
  logic [2:0]            mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_writedata;
  logic [31:0]           mem_readdata;
  logic                  mem_busywait;

  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_writedata,
    input  mem_readdata, mem_busywait,
    output cpu_readdata, cpu_busywait,
    output mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_writedata,
    output mem_readdata, mem_busywait,
    input  cpu_readdata, cpu_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purpose : combinational lane logic for sub-word accesses. Extracts and sign/
//           zero-extends the byte or halfword lane of a memory word for loads,
//           and merges store data into a memory word for read-modify-write.
// Ports   : i_size       access size code (SZ_B / SZ_H / SZ_W)
//           i_unsigned   1 = zero-extend (LBU/LHU), 0 = sign-extend
//           i_addr_lo    byte address bits [1:0]
//           i_mem_word   word read from memory
//           i_store_data right-aligned store data
//           o_load_data  formatted load result
//           o_merged     memory word with the store lane replaced
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_is_word;

  assign w_is_word = (i_size != SZ_B) && (i_size != SZ_H);

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_mem_word[7:0];
      2'd1:    w_byte = i_mem_word[15:8];
      2'd2:    w_byte = i_mem_word[23:16];
      default: w_byte = i_mem_word[31:24];
    endcase
  end

  // addr[0] is ignored for halfwords: a misaligned LH reads the aligned lane
  assign w_half = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];

  always_comb begin
    case (i_size)
      SZ_B:    o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_H:    o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load_data = i_mem_word;
    endcase
  end

  // Per byte lane: take store data if this lane is targeted, else keep memory
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic w_hit_byte;
      logic w_hit_half;
      assign w_hit_byte = (i_size == SZ_B) && (i_addr_lo == 2'(gi));
      assign w_hit_half = (i_size == SZ_H) && (i_addr_lo[1] == 1'(gi / 2));
      assign o_merged[8*gi +: 8] = w_is_word  ? i_store_data[8*gi +: 8]       :
                                   w_hit_byte ? i_store_data[7:0]             :
                                   w_hit_half ? i_store_data[8*(gi%2) +: 8]   :
                                                i_mem_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Purpose : CPU-side initiator for a word-only data memory. Turns RV32 loads
//           and stores into aligned word transactions, formats load results,
//           implements SB/SH as read-modify-write, and stalls the pipeline
//           through cpu_busywait.
// Ports   : clock       rising-edge clock
//           reset       synchronous active-low reset
//           bus         mem_access_unit_if.slave (CPU request/response and
//                       data-memory bus)
//           misaligned  (only with MISALIGN_TRAP_EN) one-cycle pulse in DONE
//                       for a rejected misaligned halfword/word access
// Config  : define MISALIGN_TRAP_EN to reject misaligned H/W accesses; when
//           undefined they silently use the aligned lane.
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input logic               clock,
  input logic               reset,
  mem_access_unit_if.slave  bus
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  state_t                r_state;
  logic [1:0]            r_size;
  logic [1:0]            r_addr_lo;
  logic                  r_unsigned;
  logic                  r_rmw;
  logic [31:0]           r_wdata;
  logic [31:0]           r_cpu_readdata;
  logic [3:0]            r_mem_read;
  logic [2:0]            r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [31:0]           r_mem_writedata;

  logic                  w_ld_req;
  logic                  w_st_req;
  logic                  w_illegal;
  logic                  w_misal;
  logic [1:0]            w_req_size;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [31:0]           w_load_data;
  logic [31:0]           w_merged;

  assign w_ld_req    = bus.cpu_read[3];
  assign w_st_req    = bus.cpu_write[2];
  assign w_illegal   = w_ld_req && w_st_req;
  assign w_req_size  = w_ld_req ? load_size(bus.cpu_read[2:0]) : store_size(bus.cpu_write[1:0]);
  assign w_word_addr = {bus.cpu_address[ADDR_WIDTH-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  logic r_misaligned;
  assign w_misal    = is_misaligned(w_req_size, bus.cpu_address[1:0]);
  assign misaligned = r_misaligned;
`else
  assign w_misal = 1'b0;
`endif

  // Lane logic is driven from latched request fields and the live memory word,
  // which is valid in both FMT and MERGE (the cycle after the sampled read).
  mem_lane_align u_lane (
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_addr_lo    (r_addr_lo),
    .i_mem_word   (bus.mem_readdata),
    .i_store_data (r_wdata),
    .o_load_data  (w_load_data),
    .o_merged     (w_merged)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_size          <= SZ_W;
      r_addr_lo       <= 2'b00;
      r_unsigned      <= 1'b0;
      r_rmw           <= 1'b0;
      r_wdata         <= '0;
      r_cpu_readdata  <= '0;
      r_mem_read      <= '0;
      r_mem_write     <= '0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
`ifdef MISALIGN_TRAP_EN
      r_misaligned    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ld_req || w_st_req) begin
            r_size     <= w_req_size;
            r_unsigned <= bus.cpu_read[2];
            r_addr_lo  <= bus.cpu_address[1:0];
            r_wdata    <= bus.cpu_writedata;
            r_rmw      <= !w_ld_req && (w_req_size != SZ_W);
            if (w_illegal || w_misal) begin
              // Rejected request: no memory strobe, cpu_readdata untouched
              r_state <= S_DONE;
`ifdef MISALIGN_TRAP_EN
              r_misaligned <= w_misal && !w_illegal;
`endif
            end else if (w_ld_req || (w_req_size != SZ_W)) begin
              r_mem_read    <= MEM_RD_WORD;
              r_mem_address <= w_word_addr;
              r_state       <= S_RD;
            end else begin
              r_mem_write     <= MEM_WR_WORD;
              r_mem_address   <= w_word_addr;
              r_mem_writedata <= bus.cpu_writedata;
              r_state         <= S_WR;
            end
          end
        end
        S_RD: begin
          if (!bus.mem_busywait) begin
            r_mem_read <= '0;
            r_state    <= r_rmw ? S_MERGE : S_FMT;
          end
        end
        S_FMT: begin
          r_cpu_readdata <= w_load_data;
          r_state        <= S_DONE;
        end
        S_MERGE: begin
          r_mem_writedata <= w_merged;
          r_mem_write     <= MEM_WR_WORD;
          r_state         <= S_WR;
        end
        S_WR: begin
          if (!bus.mem_busywait) begin
            r_mem_write <= '0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef MISALIGN_TRAP_EN
          r_misaligned <= 1'b0;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_readdata  = r_cpu_readdata;
  assign bus.mem_read      = r_mem_read;
  assign bus.mem_write     = r_mem_write;
  assign bus.mem_address   = r_mem_address;
  assign bus.mem_writedata = r_mem_writedata;
  assign bus.cpu_busywait  = ((r_state == S_IDLE) && (w_ld_req || w_st_req)) ||
                             ((r_state != S_IDLE) && (r_state != S_DONE));

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Purpose : directed self-checking bench for mem_access_unit with a small
//           word-addressed memory model behind the memory bus.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_access_unit_if #(.ADDR_WIDTH(32)) mif ();

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
`endif

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (mif)
`ifdef MISALIGN_TRAP_EN
    ,
    .misaligned (misaligned)
`endif
  );

  // Word memory: index = address[5:2]; word 0x10 and 0x18 preloaded
  logic [31:0] mem [0:15] = '{32'h0, 32'h0, 32'h0, 32'h0,
                              32'h8765_F0A1, 32'h0, 32'h1111_2222, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0};

  always @(posedge clock) begin
    if (mif.mem_read[3] && !mif.mem_busywait)
      mif.mem_readdata <= mem[mif.mem_address[5:2]];
    if (mif.mem_write[2] && !mif.mem_busywait)
      mem[mif.mem_address[5:2]] <= mif.mem_writedata;
  end

  int vectors = 0;
  int miscompares = 0;

  int          lat, rc, rf, wc;
  logic [31:0] wa, wd;
  int          wr_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request in cycle 0, then withdraw it (garbage on address/data)
  // and watch the bus until cpu_busywait drops. mem_busywait is held high for
  // cycles 1..stall.
  task automatic run_op(input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall,
                        output int o_lat, output int o_rc, output int o_rf,
                        output int o_wc, output logic [31:0] o_wa,
                        output logic [31:0] o_wd);
    o_lat = -1; o_rc = 0; o_rf = -1; o_wc = 0; o_wa = '0; o_wd = '0;
    @(posedge clock); #1;
    mif.cpu_read      = rd;
    mif.cpu_write     = wr;
    mif.cpu_address   = addr;
    mif.cpu_writedata = wdata;
    mif.mem_busywait  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (mif.mem_read != 4'b0) begin
        if (o_rf < 0) o_rf = k;
        o_rc++;
      end
      if (mif.mem_write != 3'b0) begin
        o_wc++;
        o_wa = mif.mem_address;
        o_wd = mif.mem_writedata;
      end
      if (!mif.cpu_busywait) begin
        o_lat = k;
        break;
      end
      @(posedge clock); #1;
      if (k == 0) begin
        mif.cpu_read      = '0;
        mif.cpu_write     = '0;
        mif.cpu_address   = 32'h0000_003C;
        mif.cpu_writedata = 32'hFFFF_FFFF;
      end
      mif.mem_busywait = ((k + 1) <= stall);
    end
    mif.cpu_read     = '0;
    mif.cpu_write    = '0;
    mif.mem_busywait = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mif.cpu_read      = '0;
    mif.cpu_write     = '0;
    mif.cpu_address   = '0;
    mif.cpu_writedata = '0;
    mif.mem_busywait  = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst cpu_readdata", mif.cpu_readdata, 32'h0);
    check("rst mem_read", 32'(mif.mem_read), 32'h0);
    check("rst mem_write", 32'(mif.mem_write), 32'h0);
    check("rst mem_address", mif.mem_address, 32'h0);
    check("rst mem_writedata", mif.mem_writedata, 32'h0);
    check("rst cpu_busywait", 32'(mif.cpu_busywait), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // LB 0x10
    run_op(4'b1000, 3'b000, 32'h10, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("LB data", mif.cpu_readdata, 32'hFFFF_FFA1);
    check("LB latency", lat, 3);
    check("LB rd first cycle", rf, 1);
    check("LB rd cycles", rc, 1);
    check("LB wr cycles", wc, 0);

    run_op(4'b1100, 3'b000, 32'h11, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("LBU data", mif.cpu_readdata, 32'h0000_00F0);
    run_op(4'b1001, 3'b000, 32'h12, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("LH data", mif.cpu_readdata, 32'hFFFF_8765);
    run_op(4'b1101, 3'b000, 32'h12, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("LHU data", mif.cpu_readdata, 32'h0000_8765);
    run_op(4'b1010, 3'b000, 32'h10, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("LW data", mif.cpu_readdata, 32'h8765_F0A1);
    check("LW latency", lat, 3);

    // SW 0x14
    run_op(4'b0000, 3'b110, 32'h14, 32'hDEAD_BEEF, 0, lat, rc, rf, wc, wa, wd);
    check("SW latency", lat, 2);
    check("SW wr cycles", wc, 1);
    check("SW wr address", wa, 32'h14);
    check("SW wr data", wd, 32'hDEAD_BEEF);
    check("SW rd cycles", rc, 0);
    check("SW mem word", mem[5], 32'hDEAD_BEEF);
    check("SW readdata kept", mif.cpu_readdata, 32'h8765_F0A1);

    // SB 0x13 (upper store bits must be ignored)
    run_op(4'b0000, 3'b100, 32'h13, 32'hAABB_CC42, 0, lat, rc, rf, wc, wa, wd);
    check("SB latency", lat, 4);
    check("SB rd cycles", rc, 1);
    check("SB wr cycles", wc, 1);
    check("SB wr address", wa, 32'h10);
    check("SB mem word", mem[4], 32'h4265_F0A1);

    run_op(4'b0000, 3'b101, 32'h10, 32'h5555_1234, 0, lat, rc, rf, wc, wa, wd);
    check("SH latency", lat, 4);
    check("SH mem word", mem[4], 32'h4265_1234);

    run_op(4'b1000, 3'b000, 32'h13, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("LB lane3 data", mif.cpu_readdata, 32'h0000_0042);
    run_op(4'b1010, 3'b000, 32'h13, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("LW misaligned data", mif.cpu_readdata, 32'h4265_1234);
    run_op(4'b1001, 3'b000, 32'h11, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("LH misaligned data", mif.cpu_readdata, 32'h0000_1234);

    // LW with two memory stall cycles
    run_op(4'b1010, 3'b000, 32'h10, 32'h0, 2, lat, rc, rf, wc, wa, wd);
    check("LW stall latency", lat, 5);
    check("LW stall rd cycles", rc, 3);
    check("LW stall data", mif.cpu_readdata, 32'h4265_1234);

    // Read and write both valid
    run_op(4'b1010, 3'b110, 32'h14, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("ILL latency", lat, 1);
    check("ILL rd cycles", rc, 0);
    check("ILL wr cycles", wc, 0);
    check("ILL readdata kept", mif.cpu_readdata, 32'h4265_1234);
    check("ILL mem word", mem[5], 32'hDEAD_BEEF);

    // Unused encodings: load 011 -> LW, store 11 -> SW
    run_op(4'b1011, 3'b000, 32'h14, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("L011 data", mif.cpu_readdata, 32'hDEAD_BEEF);
    run_op(4'b0000, 3'b111, 32'h1C, 32'h0BAD_F00D, 0, lat, rc, rf, wc, wa, wd);
    check("S11 latency", lat, 2);
    check("S11 mem word", mem[7], 32'h0BAD_F00D);

    // Reset during MERGE of an SB to 0x18
    @(posedge clock); #1;
    mif.cpu_write     = 3'b100;
    mif.cpu_address   = 32'h18;
    mif.cpu_writedata = 32'h99;
    @(posedge clock); #1;
    mif.cpu_write     = '0;
    mif.cpu_address   = '0;
    mif.cpu_writedata = '0;
    @(negedge clock);
    check("RSTM rd strobe", 32'(mif.mem_read), 32'h0000_000A);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("RSTM merge busy", 32'(mif.cpu_busywait), 32'h1);
    @(posedge clock); #1;
    @(negedge clock);
    check("RSTM cpu_readdata", mif.cpu_readdata, 32'h0);
    check("RSTM mem_read", 32'(mif.mem_read), 32'h0);
    check("RSTM mem_write", 32'(mif.mem_write), 32'h0);
    check("RSTM mem_address", mif.mem_address, 32'h0);
    check("RSTM mem_writedata", mif.mem_writedata, 32'h0);
    check("RSTM cpu_busywait", 32'(mif.cpu_busywait), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    wr_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (mif.mem_write != 3'b0) wr_seen++;
    end
    check("RSTM no write", wr_seen, 0);
    check("RSTM mem word", mem[6], 32'h1111_2222);

    run_op(4'b1000, 3'b000, 32'h18, 32'h0, 0, lat, rc, rf, wc, wa, wd);
    check("post-reset LB data", mif.cpu_readdata, 32'h0000_0022);
    check("post-reset LB latency", lat, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
